// File: rtl/mod_147_heartbeat_tx.sv
// mod_147_heartbeat_tx
// Heartbeat generator that sits in front of the PMA-side encoder. While the
// link is autonegotiated and not in multidrop mode, it inserts a HEARTBEAT
// burst of HB_LEN clocks after every HB_PERIOD quiet clocks. Any upstream
// activity aborts the burst and is passed through with one clock of latency.
module mod_147_heartbeat_tx #(
    parameter logic [15:0] HB_PERIOD = 16'd1000,
    parameter logic [3:0]  HB_LEN    = 4'd4
) (
    input  logic       clk,
    input  logic       pcs_reset,
    input  logic       mr_autoneg_enable,
    input  logic       an_link_good,
    input  logic       multidrop,
    input  logic       TX_EN,
    input  logic [1:0] tx_cmd_in,
    output logic [1:0] tx_cmd,
    output logic       hb_active,
    output logic [7:0] hb_cnt,
    output logic [1:0] mod_hb_tx_state
);

    typedef enum logic [1:0] {
        ST_DISABLED = 2'b00,
        ST_IDLE     = 2'b01,
        ST_SEND_HB  = 2'b10,
        ST_DEFER    = 2'b11
    } state_t;

    localparam logic [1:0] CMD_HEARTBEAT = 2'b10;
    localparam logic [1:0] CMD_NONE      = 2'b11;

    state_t      state_q, state_d;
    logic [1:0]  tx_cmd_q, tx_cmd_d;
    logic        hb_active_q, hb_active_d;
    logic [7:0]  hb_cnt_q, hb_cnt_d;
    logic [15:0] period_cnt_q, period_cnt_d;
    logic [3:0]  len_cnt_q, len_cnt_d;

    logic enable;
    logic activity;
    logic period_done;
    logic len_done;

    assign enable      = mr_autoneg_enable && an_link_good && !multidrop;
    assign activity    = TX_EN || (tx_cmd_in != CMD_NONE);
    assign period_done = (period_cnt_q == (HB_PERIOD - 16'd1));
    assign len_done    = (len_cnt_q == (HB_LEN - 4'd1));

    // Next-state and counter logic; loss of enable overrides every transition.
    always_comb begin
        state_d      = state_q;
        period_cnt_d = period_cnt_q;
        len_cnt_d    = len_cnt_q;
        hb_cnt_d     = hb_cnt_q;

        if (!enable) begin
            state_d      = ST_DISABLED;
            period_cnt_d = 16'd0;
            len_cnt_d    = 4'd0;
        end else begin
            case (state_q)
                ST_DISABLED: begin
                    if (activity) begin
                        state_d = ST_DEFER;
                    end else begin
                        state_d      = ST_IDLE;
                        period_cnt_d = 16'd0;
                    end
                end
                ST_IDLE: begin
                    if (activity) begin
                        state_d = ST_DEFER;
                    end else if (period_done) begin
                        state_d   = ST_SEND_HB;
                        len_cnt_d = 4'd0;
                    end else begin
                        period_cnt_d = period_cnt_q + 16'd1;
                    end
                end
                ST_SEND_HB: begin
                    if (activity) begin
                        // Aborted burst: no credit in hb_cnt.
                        state_d = ST_DEFER;
                    end else if (len_done) begin
                        state_d      = ST_IDLE;
                        period_cnt_d = 16'd0;
                        if (hb_cnt_q != 8'hFF) begin
                            hb_cnt_d = hb_cnt_q + 8'd1;
                        end
                    end else begin
                        len_cnt_d = len_cnt_q + 4'd1;
                    end
                end
                ST_DEFER: begin
                    if (!activity) begin
                        state_d      = ST_IDLE;
                        period_cnt_d = 16'd0;
                    end
                end
                default: begin
                    state_d = ST_DISABLED;
                end
            endcase
        end
    end

    // Output decode from the next state so the registered command lines up
    // with the state it belongs to (HEARTBEAT starts on the entry edge).
    always_comb begin
        tx_cmd_d    = tx_cmd_in;
        hb_active_d = 1'b0;
        case (state_d)
            ST_SEND_HB: begin
                tx_cmd_d    = CMD_HEARTBEAT;
                hb_active_d = 1'b1;
            end
            ST_IDLE: begin
                tx_cmd_d = CMD_NONE;
            end
            default: begin
                tx_cmd_d = tx_cmd_in;
            end
        endcase
    end

    // State and output registers; reset forces a silent, disabled transmitter.
    always_ff @(posedge clk or posedge pcs_reset) begin
        if (pcs_reset) begin
            state_q      <= ST_DISABLED;
            tx_cmd_q     <= CMD_NONE;
            hb_active_q  <= 1'b0;
            hb_cnt_q     <= 8'd0;
            period_cnt_q <= 16'd0;
            len_cnt_q    <= 4'd0;
        end else begin
            state_q      <= state_d;
            tx_cmd_q     <= tx_cmd_d;
            hb_active_q  <= hb_active_d;
            hb_cnt_q     <= hb_cnt_d;
            period_cnt_q <= period_cnt_d;
            len_cnt_q    <= len_cnt_d;
        end
    end

    assign tx_cmd          = tx_cmd_q;
    assign hb_active       = hb_active_q;
    assign hb_cnt          = hb_cnt_q;
    assign mod_hb_tx_state = state_q;

endmodule

// File: tb/tb_mod_147_heartbeat_tx.sv
// Directed testbench for mod_147_heartbeat_tx with HB_PERIOD=8, HB_LEN=2.
module tb_mod_147_heartbeat_tx;

    localparam logic [1:0] C_BEACON = 2'b00;
    localparam logic [1:0] C_COMMIT = 2'b01;
    localparam logic [1:0] C_HB     = 2'b10;
    localparam logic [1:0] C_NONE   = 2'b11;

    localparam logic [1:0] S_DIS  = 2'b00;
    localparam logic [1:0] S_IDLE = 2'b01;
    localparam logic [1:0] S_SEND = 2'b10;
    localparam logic [1:0] S_DEF  = 2'b11;

    logic       clk;
    logic       pcs_reset;
    logic       mr_autoneg_enable;
    logic       an_link_good;
    logic       multidrop;
    logic       TX_EN;
    logic [1:0] tx_cmd_in;
    logic [1:0] tx_cmd;
    logic       hb_active;
    logic [7:0] hb_cnt;
    logic [1:0] mod_hb_tx_state;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic       an_en;
        logic       link;
        logic       md;
        logic       txen;
        logic [1:0] cin;
        logic [1:0] ecmd;
        logic       ehb;
        logic [1:0] est;
        logic [7:0] ecnt;
    } vec_t;

    vec_t tbl[$];

    mod_147_heartbeat_tx #(
        .HB_PERIOD(16'd8),
        .HB_LEN   (4'd2)
    ) dut (
        .clk              (clk),
        .pcs_reset        (pcs_reset),
        .mr_autoneg_enable(mr_autoneg_enable),
        .an_link_good     (an_link_good),
        .multidrop        (multidrop),
        .TX_EN            (TX_EN),
        .tx_cmd_in        (tx_cmd_in),
        .tx_cmd           (tx_cmd),
        .hb_active        (hb_active),
        .hb_cnt           (hb_cnt),
        .mod_hb_tx_state  (mod_hb_tx_state)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic add(input logic an, input logic lk, input logic md, input logic te,
                       input logic [1:0] cin, input logic [1:0] ecmd, input logic ehb,
                       input logic [1:0] est, input logic [7:0] ecnt);
        vec_t v;
        v.an_en = an; v.link = lk; v.md = md; v.txen = te; v.cin = cin;
        v.ecmd = ecmd; v.ehb = ehb; v.est = est; v.ecnt = ecnt;
        tbl.push_back(v);
    endtask

    task automatic set_in(input logic an, input logic lk, input logic md,
                          input logic te, input logic [1:0] cin);
        mr_autoneg_enable = an;
        an_link_good      = lk;
        multidrop         = md;
        TX_EN             = te;
        tx_cmd_in         = cin;
    endtask

    initial begin
        int n;
        bit found;
        bit sat_seen;
        bit sat_drop;
        logic [1:0] prev_cmd;
        int hb_seen;

        // Expected-response table, one row per clock, starting from reset release.
        add(0, 1, 0, 0, C_COMMIT, C_COMMIT, 0, S_DIS, 8'd0);
        add(1, 0, 0, 0, C_BEACON, C_BEACON, 0, S_DIS, 8'd0);
        add(1, 1, 1, 0, C_HB,     C_HB,     0, S_DIS, 8'd0);
        add(1, 1, 0, 0, C_COMMIT, C_COMMIT, 0, S_DEF, 8'd0);
        add(1, 1, 0, 1, C_NONE,   C_NONE,   0, S_DEF, 8'd0);
        add(1, 1, 0, 0, C_NONE,   C_NONE,   0, S_IDLE, 8'd0);
        for (int i = 0; i < 7; i++) add(1, 1, 0, 0, C_NONE, C_NONE, 0, S_IDLE, 8'd0);
        add(1, 1, 0, 0, C_NONE,   C_HB,     1, S_SEND, 8'd0);
        add(1, 1, 0, 0, C_NONE,   C_HB,     1, S_SEND, 8'd0);
        add(1, 1, 0, 0, C_NONE,   C_NONE,   0, S_IDLE, 8'd1);
        for (int i = 0; i < 7; i++) add(1, 1, 0, 0, C_NONE, C_NONE, 0, S_IDLE, 8'd1);
        add(1, 1, 0, 0, C_NONE,   C_HB,     1, S_SEND, 8'd1);
        add(1, 1, 0, 1, C_NONE,   C_NONE,   0, S_DEF,  8'd1);
        add(1, 1, 0, 0, C_NONE,   C_NONE,   0, S_IDLE, 8'd1);
        add(1, 1, 0, 0, C_HB,     C_HB,     0, S_DEF,  8'd1);
        add(1, 1, 0, 0, C_HB,     C_HB,     0, S_DEF,  8'd1);
        add(1, 1, 0, 0, C_NONE,   C_NONE,   0, S_IDLE, 8'd1);

        // Reset state, observed before any clock edge.
        set_in(1, 1, 1, 0, C_NONE);
        pcs_reset = 1'b0;
        #1 pcs_reset = 1'b1;
        #2;
        check("rst_cmd",   int'(tx_cmd), int'(C_NONE));
        check("rst_hb",    int'(hb_active), 0);
        check("rst_cnt",   int'(hb_cnt), 0);
        check("rst_state", int'(mod_hb_tx_state), int'(S_DIS));
        tick();
        tick();
        check("rst_hold_state", int'(mod_hb_tx_state), int'(S_DIS));
        pcs_reset = 1'b0;

        // Table-driven section.
        foreach (tbl[i]) begin
            set_in(tbl[i].an_en, tbl[i].link, tbl[i].md, tbl[i].txen, tbl[i].cin);
            tick();
            check($sformatf("row%0d_cmd", i),   int'(tx_cmd), int'(tbl[i].ecmd));
            check($sformatf("row%0d_hb", i),    int'(hb_active), int'(tbl[i].ehb));
            check($sformatf("row%0d_state", i), int'(mod_hb_tx_state), int'(tbl[i].est));
            check($sformatf("row%0d_cnt", i),   int'(hb_cnt), int'(tbl[i].ecnt));
        end

        // Traffic defers the timer: COMMIT passes through, then HEARTBEAT 9 clocks later.
        for (int i = 0; i < 3; i++) begin
            set_in(1, 1, 0, 0, C_COMMIT);
            tick();
            check($sformatf("commit%0d_cmd", i), int'(tx_cmd), int'(C_COMMIT));
            check($sformatf("commit%0d_state", i), int'(mod_hb_tx_state), int'(S_DEF));
        end
        set_in(1, 1, 0, 0, C_NONE);
        found = 0;
        n = 0;
        for (int k = 1; k <= 20 && !found; k++) begin
            tick();
            if (tx_cmd == C_HB) begin
                found = 1;
                n = k;
            end
        end
        check("defer_hb_found", int'(found), 1);
        check("defer_hb_delay", n, 9);

        // Disable via multidrop: passthrough with one clock lag and no heartbeat.
        hb_seen = 0;
        for (int i = 0; i < 100; i++) begin
            set_in(1, 1, 1, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)));
            prev_cmd = tx_cmd_in;
            tick();
            check("dis_state", int'(mod_hb_tx_state), int'(S_DIS));
            check("dis_pass", int'(tx_cmd), int'(prev_cmd));
            if (hb_active) hb_seen++;
        end
        check("dis_no_hb", hb_seen, 0);

        // Saturation over 300+ idle bursts.
        set_in(1, 1, 0, 0, C_NONE);
        sat_seen = 0;
        sat_drop = 0;
        for (int i = 0; i < 3020; i++) begin
            tick();
            if (hb_cnt == 8'hFF) sat_seen = 1;
            else if (sat_seen) sat_drop = 1;
        end
        check("sat_reached", int'(sat_seen), 1);
        check("sat_no_drop", int'(sat_drop), 0);
        check("sat_value", int'(hb_cnt), 255);

        // Asynchronous reset in the middle of a burst.
        found = 0;
        for (int k = 0; k < 20 && !found; k++) begin
            tick();
            if (hb_active) found = 1;
        end
        check("burst_found", int'(found), 1);
        #2 pcs_reset = 1'b1;
        #1;
        check("arst_cmd",   int'(tx_cmd), int'(C_NONE));
        check("arst_hb",    int'(hb_active), 0);
        check("arst_cnt",   int'(hb_cnt), 0);
        check("arst_state", int'(mod_hb_tx_state), int'(S_DIS));
        tick();
        check("arst_hold_cnt", int'(hb_cnt), 0);
        #2 pcs_reset = 1'b0;

        // Idle heartbeat timeline from reset release.
        for (int k = 1; k <= 21; k++) begin
            logic [1:0] ecmd;
            int ecnt;
            tick();
            ecmd = (k == 9 || k == 10 || k == 19 || k == 20) ? C_HB : C_NONE;
            ecnt = (k < 11) ? 0 : ((k < 21) ? 1 : 2);
            check($sformatf("tl%0d_cmd", k), int'(tx_cmd), int'(ecmd));
            check($sformatf("tl%0d_cnt", k), int'(hb_cnt), ecnt);
            if (k == 1) check("tl1_state", int'(mod_hb_tx_state), int'(S_IDLE));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
